// File: rtl/instr_decode_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of
// {instr, pc} that presents the split MIPS fields and derived values of its head entry.
module instr_decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      immediate,
  output logic [31:0]      imm_sext,
  output logic [31:0]      imm_zext,
  output logic [25:0]      instr_idx,
  output logic [31:0]      jump_target,
  output logic             is_rtype,
  output logic             is_jtype,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready and out_valid depend on count only, so neither side sees a combinational
  // path from the other; a full queue refuses a push even if a pop happens that cycle.
  logic [31:0]      mem_instr [DEPTH];
  logic [31:0]      mem_pc    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a dropped word (reset or flush cycle) is never written.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  logic [31:0] head_instr;
  logic [3:0]  pc4_hi;

  assign head_instr = out_valid ? mem_instr[rd_ptr] : 32'd0;
  assign out_pc     = out_valid ? mem_pc[rd_ptr]    : 32'd0;
  assign pc4_hi     = 4'((out_pc + 32'd4) >> 28);

  assign opcode      = head_instr[31:26];
  assign rs          = head_instr[25:21];
  assign rt          = head_instr[20:16];
  assign rd          = head_instr[15:11];
  assign shamt       = head_instr[10:6];
  assign funct       = head_instr[5:0];
  assign immediate   = head_instr[15:0];
  assign imm_sext    = {{16{head_instr[15]}}, head_instr[15:0]};
  assign imm_zext    = {16'b0, head_instr[15:0]};
  assign instr_idx   = head_instr[25:0];
  assign jump_target = out_valid ? {pc4_hi, head_instr[25:0], 2'b00} : 32'd0;
  assign is_rtype    = out_valid && (opcode == 6'h00);
  assign is_jtype    = out_valid && (opcode == 6'h02 || opcode == 6'h03);

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based reference model.
module tb_instr_decode_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, out_ready;
  logic [31:0]      in_instr, in_pc;
  logic             in_ready, out_valid;
  logic [31:0]      out_pc, imm_sext, imm_zext, jump_target;
  logic [5:0]       opcode, funct;
  logic [4:0]       rs, rt, rd, shamt;
  logic [15:0]      immediate;
  logic [25:0]      instr_idx;
  logic             is_rtype, is_jtype;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [63:0] exp_q[$];

  instr_decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .imm_sext(imm_sext), .imm_zext(imm_zext),
    .instr_idx(instr_idx), .jump_target(jump_target),
    .is_rtype(is_rtype), .is_jtype(is_jtype), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a FIFO of {pc, instr}, updated with the rules of each edge
  always @(posedge clk) begin
    bit do_push, do_pop;
    started = 1;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_pc, in_instr});
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [31:0] e_instr, e_pc, e_jt;
    bit e_valid;
    if (started) begin
      e_valid = (exp_q.size() > 0);
      e_instr = e_valid ? exp_q[0][31:0]  : 32'd0;
      e_pc    = e_valid ? exp_q[0][63:32] : 32'd0;
      e_jt    = e_valid ? (((e_pc + 32'd4) & 32'hF000_0000) | ({6'd0, e_instr[25:0]} << 2)) : 32'd0;
      chk("count",       32'(count),      32'(exp_q.size()));
      chk("out_valid",   32'(out_valid),  32'(e_valid));
      chk("in_ready",    32'(in_ready),   32'(exp_q.size() < DEPTH));
      chk("out_pc",      out_pc,          e_pc);
      chk("opcode",      32'(opcode),     e_instr >> 26);
      chk("rs",          32'(rs),         (e_instr >> 21) & 32'h1F);
      chk("rt",          32'(rt),         (e_instr >> 16) & 32'h1F);
      chk("rd",          32'(rd),         (e_instr >> 11) & 32'h1F);
      chk("shamt",       32'(shamt),      (e_instr >> 6) & 32'h1F);
      chk("funct",       32'(funct),      e_instr & 32'h3F);
      chk("immediate",   32'(immediate),  e_instr & 32'hFFFF);
      chk("imm_sext",    imm_sext,        32'($signed(e_instr[15:0])));
      chk("imm_zext",    imm_zext,        e_instr & 32'hFFFF);
      chk("instr_idx",   32'(instr_idx),  e_instr & 32'h03FF_FFFF);
      chk("jump_target", jump_target,     e_jt);
      chk("is_rtype",    32'(is_rtype),   32'(e_valid && (e_instr >> 26) == 0));
      chk("is_jtype",    32'(is_jtype),   32'(e_valid && ((e_instr >> 26) == 2 || (e_instr >> 26) == 3)));
    end
  end

  // driver tasks: inputs change on the falling edge, one rising edge per tick
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  task automatic idle_drain();
    drive(0, 32'd0, 32'd0, 1, 0);
    repeat (DEPTH + 1) tick();
  endtask

  initial begin
    rst_n = 0;
    drive(0, 32'd0, 32'd0, 0, 0);
    repeat (2) tick();
    chk("rst count", 32'(count), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst opcode", 32'(opcode), 32'd0);
    chk("rst imm_sext", imm_sext, 32'd0);
    rst_n = 1;

    // first word, then pop-and-replace to bring each pattern to the head
    drive(1, 32'h8C22_0010, 32'h0040_0000, 0, 0); tick();
    chk("lw out_valid", 32'(out_valid), 32'd1);
    chk("lw opcode", 32'(opcode), 32'h23);
    chk("lw rs", 32'(rs), 32'd1);
    chk("lw rt", 32'(rt), 32'd2);
    chk("lw imm_sext", imm_sext, 32'h0000_0010);
    drive(1, 32'h2021_FFFF, 32'h0040_0004, 1, 0); tick();
    chk("addi imm_sext", imm_sext, 32'hFFFF_FFFF);
    chk("addi imm_zext", imm_zext, 32'h0000_FFFF);
    drive(1, 32'h0C10_0000, 32'hF000_0000, 1, 0); tick();
    chk("jal jump_target", jump_target, 32'hF040_0000);
    chk("jal is_jtype", 32'(is_jtype), 32'd1);
    drive(1, 32'h00A6_3020, 32'h0000_0010, 1, 0); tick();
    chk("add is_rtype", 32'(is_rtype), 32'd1);
    chk("add rd", 32'(rd), 32'd6);
    chk("add shamt", 32'(shamt), 32'd0);
    chk("add funct", 32'(funct), 32'h20);
    drive(1, 32'h0800_0001, 32'hFFFF_FFFC, 1, 0); tick();
    chk("j wrap jump_target", jump_target, 32'h0000_0004);
    idle_drain();

    // full / back-pressure
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h1000_0000 + i, 32'h100 + 4 * i, 0, 0); tick();
    end
    chk("full count", 32'(count), 32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    drive(1, 32'hDEAD_BEEF, 32'h0000_0BAD, 1, 0); tick();
    chk("full pop count", 32'(count), 32'd3);
    chk("full pop head pc", out_pc, 32'h0000_0104);
    idle_drain();

    // streaming through several wraps
    drive(1, 32'h2000_0000, 32'h200, 0, 0); tick();
    for (int i = 1; i <= 20; i++) begin
      drive(1, 32'h2000_0000 + i, 32'h200 + 4 * i, 1, 0); tick();
      chk("stream count", 32'(count), 32'd1);
    end
    chk("stream last pc", out_pc, 32'h200 + 4 * 20);
    idle_drain();

    // flush with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3000_0000 + i, 32'h300 + 4 * i, 0, 0); tick();
    end
    chk("preflush count", 32'(count), 32'd3);
    drive(1, 32'hBADB_AD00, 32'h0000_0666, 0, 1); tick();
    chk("flush count", 32'(count), 32'd0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    drive(1, 32'h3400_0000, 32'h0000_0400, 0, 0); tick();
    chk("postflush head pc", out_pc, 32'h0000_0400);
    idle_drain();

    // reset in mid-operation
    drive(1, 32'h1111_1111, 32'h500, 0, 0); tick(); tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("midrst count", 32'(count), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom(),
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC),
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) in_instr[31:26] = 6'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1;
    idle_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
